// File: rtl/pcie_rx_block_lock.sv
`default_nettype none
// ============================================================================
// Module   : pcie_rx_block_lock
// Purpose  : Per-lane 128b/130b sync-header block-alignment engine for the
//            PCIe Gen3+/Gen4 RX PCS. Each lane qualifies sync headers,
//            requests gearbox bit-slips while hunting, and reports block lock.
//            Link-wide lock and a lock-lost pulse are also produced.
// Options  : PCIE_BLK_ERR_CNT_EN - adds the per-lane saturating bad-header
//            counters (err_cnt) and their clear input (err_clr).
// Revision : 1.0 - initial release
// ============================================================================
module pcie_rx_block_lock #(
  parameter int LANES    = 16,
  parameter int LOCK_CNT = 8,
  parameter int BAD_MAX  = 4,
  parameter int WINDOW   = 64
) (
  input  logic               clk_phy,
  input  logic               rst_phy,
  input  logic [LANES-1:0]   cfg_lane_en,
  input  logic [LANES-1:0]   rx_hdr_valid,
  input  logic [2*LANES-1:0] rx_hdr,
  output logic [LANES-1:0]   blk_slip,
  output logic [LANES-1:0]   blk_lock,
  output logic [LANES-1:0]   blk_valid,
  output logic [LANES-1:0]   blk_is_data,
  output logic [LANES-1:0]   blk_is_os,
  output logic               link_lock,
  output logic               lock_lost
`ifdef PCIE_BLK_ERR_CNT_EN
  ,
  input  logic               err_clr,
  output logic [8*LANES-1:0] err_cnt
`endif
);

  localparam int c_GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int c_WIN_W  = $clog2(WINDOW + 1);
  localparam int c_BAD_W  = $clog2(BAD_MAX + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lane_state_t;

  // Per-lane "dropped lock on errors this cycle" indications
  logic [LANES-1:0] w_lost;

  logic r_link_lock;
  logic r_lock_lost;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      lane_state_t         r_state;
      lane_state_t         w_state_nxt;
      logic [c_GOOD_W-1:0] r_good_cnt;
      logic [c_GOOD_W-1:0] w_good_cnt_nxt;
      logic [c_WIN_W-1:0]  r_win_cnt;
      logic [c_WIN_W-1:0]  w_win_cnt_nxt;
      logic [c_WIN_W-1:0]  w_win_inc;
      logic [c_BAD_W-1:0]  r_bad_cnt;
      logic [c_BAD_W-1:0]  w_bad_cnt_nxt;
      logic [c_BAD_W-1:0]  w_bad_inc;
      logic [1:0]          w_hdr;
      logic                w_hdr_good;
      logic                w_act;
      logic                w_slip_nxt;
      logic                w_fwd_nxt;
      logic                w_lost_nxt;
      logic                r_slip;
      logic                r_lock;
      logic                r_valid;
      logic                r_is_data;
      logic                r_is_os;

      assign w_hdr      = rx_hdr[2*i +: 2];
      assign w_hdr_good = (w_hdr == 2'b10) || (w_hdr == 2'b01);
      assign w_act      = cfg_lane_en[i] & rx_hdr_valid[i];
      assign w_win_inc  = r_win_cnt + 1'b1;
      assign w_bad_inc  = r_bad_cnt + 1'b1;

      // Next-state / counter / output-request logic of the lane sync FSM
      always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_win_cnt_nxt  = r_win_cnt;
        w_bad_cnt_nxt  = r_bad_cnt;
        w_slip_nxt     = 1'b0;
        w_fwd_nxt      = 1'b0;
        w_lost_nxt     = 1'b0;
        if (!cfg_lane_en[i]) begin
          // Disabled lane parks in HUNT with clean counters
          w_state_nxt    = ST_HUNT;
          w_good_cnt_nxt = '0;
          w_win_cnt_nxt  = '0;
          w_bad_cnt_nxt  = '0;
        end else if (w_act) begin
          case (r_state)
            ST_HUNT: begin
              if (w_hdr_good) begin
                w_state_nxt    = ST_VERIFY;
                w_good_cnt_nxt = c_GOOD_W'(1);
              end else begin
                w_slip_nxt = 1'b1;
              end
            end
            ST_VERIFY: begin
              if (w_hdr_good) begin
                if (r_good_cnt == c_GOOD_W'(LOCK_CNT - 1)) begin
                  w_state_nxt    = ST_LOCKED;
                  w_good_cnt_nxt = '0;
                  w_win_cnt_nxt  = '0;
                  w_bad_cnt_nxt  = '0;
                end else begin
                  w_good_cnt_nxt = r_good_cnt + 1'b1;
                end
              end else begin
                w_state_nxt    = ST_HUNT;
                w_good_cnt_nxt = '0;
                w_slip_nxt     = 1'b1;
              end
            end
            ST_LOCKED: begin
              w_fwd_nxt     = w_hdr_good;
              w_win_cnt_nxt = w_win_inc;
              if (!w_hdr_good) begin
                w_bad_cnt_nxt = w_bad_inc;
              end
              // The error check runs before the window wrap so a bad header
              // on the last block of a window still counts against lock.
              if (!w_hdr_good && (w_bad_inc == c_BAD_W'(BAD_MAX))) begin
                w_state_nxt    = ST_HUNT;
                w_good_cnt_nxt = '0;
                w_win_cnt_nxt  = '0;
                w_bad_cnt_nxt  = '0;
                w_slip_nxt     = 1'b1;
                w_lost_nxt     = 1'b1;
              end else if (w_win_inc == c_WIN_W'(WINDOW)) begin
                w_win_cnt_nxt = '0;
                w_bad_cnt_nxt = '0;
              end
            end
            default: begin
              w_state_nxt    = ST_HUNT;
              w_good_cnt_nxt = '0;
              w_win_cnt_nxt  = '0;
              w_bad_cnt_nxt  = '0;
            end
          endcase
        end
      end

      // State, counters and registered lane outputs
      always_ff @(posedge clk_phy or posedge rst_phy) begin
        if (rst_phy) begin
          r_state    <= ST_HUNT;
          r_good_cnt <= '0;
          r_win_cnt  <= '0;
          r_bad_cnt  <= '0;
          r_slip     <= 1'b0;
          r_lock     <= 1'b0;
          r_valid    <= 1'b0;
          r_is_data  <= 1'b0;
          r_is_os    <= 1'b0;
        end else begin
          r_state    <= w_state_nxt;
          r_good_cnt <= w_good_cnt_nxt;
          r_win_cnt  <= w_win_cnt_nxt;
          r_bad_cnt  <= w_bad_cnt_nxt;
          r_slip     <= w_slip_nxt;
          r_lock     <= (w_state_nxt == ST_LOCKED);
          r_valid    <= w_fwd_nxt;
          r_is_data  <= w_fwd_nxt & (w_hdr == 2'b10);
          r_is_os    <= w_fwd_nxt & (w_hdr == 2'b01);
        end
      end

      assign blk_slip[i]    = r_slip;
      assign blk_lock[i]    = r_lock;
      assign blk_valid[i]   = r_valid;
      assign blk_is_data[i] = r_is_data;
      assign blk_is_os[i]   = r_is_os;
      assign w_lost[i]      = w_lost_nxt;

`ifdef PCIE_BLK_ERR_CNT_EN
      logic [7:0] r_err_cnt;

      // Saturating bad-header counter; a clear wins over a same-cycle increment
      always_ff @(posedge clk_phy or posedge rst_phy) begin
        if (rst_phy) begin
          r_err_cnt <= 8'd0;
        end else if (err_clr) begin
          r_err_cnt <= 8'd0;
        end else if (w_act && !w_hdr_good && (r_err_cnt != 8'hFF)) begin
          r_err_cnt <= r_err_cnt + 8'd1;
        end
      end

      assign err_cnt[8*i +: 8] = r_err_cnt;
`endif
    end
  endgenerate

  // Link lock from registered lane locks; lock_lost merges same-cycle losses
  always_ff @(posedge clk_phy or posedge rst_phy) begin
    if (rst_phy) begin
      r_link_lock <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_link_lock <= (|cfg_lane_en) && (&(blk_lock | ~cfg_lane_en));
      r_lock_lost <= |w_lost;
    end
  end

  assign link_lock = r_link_lock;
  assign lock_lost = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_pcie_rx_block_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_rx_block_lock
// Purpose  : Self-checking bench for pcie_rx_block_lock. A lane model based on
//            good-header run length and per-window bad counts predicts every
//            output each cycle; directed literal checks pin the model.
//            Define PCIE_BLK_ERR_CNT_EN to also exercise err_cnt/err_clr.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_rx_block_lock;

  localparam int NL   = 16;
  localparam int LOCK = 8;
  localparam int BADM = 4;
  localparam int WIN  = 64;

  logic            clk_phy = 1'b0;
  logic            rst_phy;
  logic [NL-1:0]   cfg_lane_en;
  logic [NL-1:0]   rx_hdr_valid;
  logic [2*NL-1:0] rx_hdr;
  logic [NL-1:0]   blk_slip, blk_lock, blk_valid, blk_is_data, blk_is_os;
  logic            link_lock, lock_lost;
`ifdef PCIE_BLK_ERR_CNT_EN
  logic            err_clr;
  logic [8*NL-1:0] err_cnt;
`endif

  pcie_rx_block_lock #(.LANES(NL), .LOCK_CNT(LOCK), .BAD_MAX(BADM), .WINDOW(WIN)) dut (
    .clk_phy      (clk_phy),
    .rst_phy      (rst_phy),
    .cfg_lane_en  (cfg_lane_en),
    .rx_hdr_valid (rx_hdr_valid),
    .rx_hdr       (rx_hdr),
    .blk_slip     (blk_slip),
    .blk_lock     (blk_lock),
    .blk_valid    (blk_valid),
    .blk_is_data  (blk_is_data),
    .blk_is_os    (blk_is_os),
    .link_lock    (link_lock),
    .lock_lost    (lock_lost)
`ifdef PCIE_BLK_ERR_CNT_EN
    ,
    .err_clr      (err_clr),
    .err_cnt      (err_cnt)
`endif
  );

  always #5 clk_phy = ~clk_phy;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit            m_locked [NL];
  int            m_run    [NL];   // consecutive good headers while not locked
  int            m_wpos   [NL];   // blocks seen in current window
  int            m_wbad   [NL];   // bad headers in current window
  int            m_err    [NL];
  logic [NL-1:0] e_slip = '0, e_lock = '0, e_valid = '0, e_data = '0, e_os = '0;
  logic          e_link = 1'b0, e_lost = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_locked[i] = 1'b0; m_run[i] = 0; m_wpos[i] = 0; m_wbad[i] = 0; m_err[i] = 0;
    end
    e_slip = '0; e_lock = '0; e_valid = '0; e_data = '0; e_os = '0;
    e_link = 1'b0; e_lost = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] h;
    bit         good;
    bit         any_lost;
    any_lost = 1'b0;
    e_link = (cfg_lane_en != '0) && ((e_lock | ~cfg_lane_en) == '1);
    for (int i = 0; i < NL; i++) begin
      h = rx_hdr[2*i +: 2];
      good = (h == 2'b10) || (h == 2'b01);
      e_slip[i] = 1'b0; e_valid[i] = 1'b0; e_data[i] = 1'b0; e_os[i] = 1'b0;
      if (!cfg_lane_en[i]) begin
        m_locked[i] = 1'b0; m_run[i] = 0; m_wpos[i] = 0; m_wbad[i] = 0;
      end else if (rx_hdr_valid[i]) begin
        if (!good && m_err[i] < 255) m_err[i]++;
        if (!m_locked[i]) begin
          if (good) begin
            m_run[i]++;
            if (m_run[i] == LOCK) begin
              m_locked[i] = 1'b1; m_run[i] = 0; m_wpos[i] = 0; m_wbad[i] = 0;
            end
          end else begin
            m_run[i] = 0; e_slip[i] = 1'b1;
          end
        end else begin
          e_valid[i] = good;
          e_data[i]  = good && (h == 2'b10);
          e_os[i]    = good && (h == 2'b01);
          m_wpos[i]++;
          if (!good) m_wbad[i]++;
          if (m_wbad[i] == BADM) begin
            m_locked[i] = 1'b0; m_run[i] = 0; m_wpos[i] = 0; m_wbad[i] = 0;
            e_slip[i] = 1'b1; any_lost = 1'b1;
          end else if (m_wpos[i] == WIN) begin
            m_wpos[i] = 0; m_wbad[i] = 0;
          end
        end
      end
      e_lock[i] = m_locked[i];
    end
`ifdef PCIE_BLK_ERR_CNT_EN
    if (err_clr) for (int i = 0; i < NL; i++) m_err[i] = 0;
`endif
    e_lost = any_lost;
  endtask

  // Model advances on each clock edge, or immediately on reset
  initial begin
    model_reset();
    forever begin
      @(posedge clk_phy or posedge rst_phy);
      if (rst_phy) model_reset();
      else         model_step();
    end
  end

  // Compare every output against the model away from the active edge
  initial begin
    forever begin
      @(negedge clk_phy);
      check("slip",  blk_slip,    e_slip);
      check("lock",  blk_lock,    e_lock);
      check("valid", blk_valid,   e_valid);
      check("data",  blk_is_data, e_data);
      check("os",    blk_is_os,   e_os);
      check("link",  link_lock,   e_link);
      check("lost",  lock_lost,   e_lost);
`ifdef PCIE_BLK_ERR_CNT_EN
      for (int i = 0; i < NL; i++) check("err_cnt", err_cnt[8*i +: 8], m_err[i][7:0]);
`endif
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [2*NL-1:0] hx(input logic [1:0] h);
    return {NL{h}};
  endfunction

  task automatic drive(input logic [NL-1:0] v, input logic [2*NL-1:0] h);
    rx_hdr_valid = v;
    rx_hdr       = h;
    @(posedge clk_phy);
    #1;
  endtask

  task automatic idle();
    drive('0, '0);
  endtask

  initial begin
    rst_phy      = 1'b1;
    cfg_lane_en  = '0;
    rx_hdr_valid = '0;
    rx_hdr       = '0;
`ifdef PCIE_BLK_ERR_CNT_EN
    err_clr      = 1'b0;
`endif
    repeat (3) @(posedge clk_phy);
    #1;
    check("rst_lock", blk_lock, '0);
    check("rst_link", link_lock, 1'b0);
    check("rst_slip", blk_slip, '0);
    rst_phy = 1'b0;
    cfg_lane_en = 16'h0001;
    idle();

    // Lock on lane 0 after 8 good headers; link follows one cycle later
    for (int k = 0; k < LOCK - 1; k++) drive(16'h0001, hx(2'b10));
    check("t1_lock_7", blk_lock, 16'h0000);
    drive(16'h0001, hx(2'b10));
    check("t1_lock_8", blk_lock, 16'h0001);
    check("t1_link_early", link_lock, 1'b0);
    check("t1_no_fwd_lockblk", blk_valid, 16'h0000);
    idle();
    check("t1_link", link_lock, 1'b1);
    drive(16'h0001, hx(2'b01));
    check("t1_os_valid", blk_valid, 16'h0001);
    check("t1_os", blk_is_os, 16'h0001);
    check("t1_os_notdata", blk_is_data, 16'h0000);
    drive(16'h0001, hx(2'b10));
    check("t1_data", blk_is_data, 16'h0001);

    // Four bad headers within one window drop lock
    for (int k = 0; k < BADM - 1; k++) begin
      drive(16'h0001, hx(2'b00));
      check("t3_still_locked", blk_lock, 16'h0001);
      check("t3_bad_not_fwd", blk_valid, 16'h0000);
    end
    drive(16'h0001, hx(2'b11));
    check("t3_lock_dropped", blk_lock, 16'h0000);
    check("t3_lost_pulse", lock_lost, 1'b1);
    check("t3_slip_pulse", blk_slip, 16'h0001);
    idle();
    check("t3_lost_end", lock_lost, 1'b0);
    check("t3_slip_end", blk_slip, 16'h0000);

    // HUNT bad -> single slip; VERIFY bad after 5 good -> slip, full relock needed
    drive(16'h0001, hx(2'b00));
    check("t2_hunt_slip", blk_slip, 16'h0001);
    idle();
    check("t2_hunt_slip_end", blk_slip, 16'h0000);
    for (int k = 0; k < 5; k++) drive(16'h0001, hx(2'b10));
    drive(16'h0001, hx(2'b11));
    check("t2_verify_slip", blk_slip, 16'h0001);
    for (int k = 0; k < LOCK - 1; k++) drive(16'h0001, hx(2'b10));
    check("t2_relock_7", blk_lock, 16'h0000);
    drive(16'h0001, hx(2'b01));
    check("t2_relock_8", blk_lock, 16'h0001);

    // Ten windows with 3 bad each (incl. last block of window) stay locked
    for (int w = 0; w < 10; w++) begin
      for (int b = 0; b < WIN; b++)
        drive(16'h0001, (b == 0 || b == 31 || b == WIN - 1) ? hx(2'b00) : hx(2'b10));
      check("t3_window_locked", blk_lock, 16'h0001);
    end
    // Fourth bad landing on the last block of a window still drops lock
    for (int b = 0; b < WIN - 1; b++)
      drive(16'h0001, (b >= WIN - 4) ? hx(2'b00) : hx(2'b10));
    check("t3_lastblk_pre", blk_lock, 16'h0001);
    drive(16'h0001, hx(2'b11));
    check("t3_lastblk_drop", blk_lock, 16'h0000);
    check("t3_lastblk_lost", lock_lost, 1'b1);

    // x16 lock, then narrow to x8: no lock_lost, link stays up
    cfg_lane_en = 16'hFFFF;
    idle();
    for (int k = 0; k < LOCK; k++) drive(16'hFFFF, hx(2'b10));
    check("t4_all_lock", blk_lock, 16'hFFFF);
    idle();
    check("t4_link", link_lock, 1'b1);
    cfg_lane_en = 16'h00FF;
    drive(16'hFFFF, hx(2'b10));
    check("t4_narrow_lock", blk_lock, 16'h00FF);
    check("t4_no_lost", lock_lost, 1'b0);
    check("t4_link_kept", link_lock, 1'b1);
    check("t4_valid", blk_valid, 16'h00FF);

    // All enabled lanes lose lock together -> one lock_lost pulse
    for (int k = 0; k < BADM; k++) drive(16'hFFFF, hx(2'b00));
    check("t4_multi_lost", lock_lost, 1'b1);
    check("t4_multi_slip", blk_slip, 16'h00FF);
    idle();
    check("t4_multi_lost_end", lock_lost, 1'b0);
    check("t4_link_down", link_lock, 1'b0);

    // Reset mid-LOCKED with traffic, then full relock
    for (int k = 0; k < LOCK + 3; k++) drive(16'hFFFF, hx(2'b10));
    check("t5_locked", blk_lock, 16'h00FF);
    rx_hdr_valid = 16'hFFFF;
    rst_phy = 1'b1;
    #1;
    check("t5_rst_lock", blk_lock, '0);
    check("t5_rst_link", link_lock, 1'b0);
    check("t5_rst_valid", blk_valid, '0);
    @(posedge clk_phy);
    #1;
    rst_phy = 1'b0;
    for (int k = 0; k < LOCK - 1; k++) drive(16'hFFFF, hx(2'b10));
    check("t5_relock_7", blk_lock, 16'h0000);
    drive(16'hFFFF, hx(2'b10));
    check("t5_relock_8", blk_lock, 16'h00FF);

`ifdef PCIE_BLK_ERR_CNT_EN
    // Saturating error counter on lane 3 and clear-wins-over-increment
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    check("t6_cleared", err_cnt, '0);
    for (int k = 0; k < 300; k++) drive(16'h0008, 32'h0000_0000);
    check("t6_sat", err_cnt[31:24], 8'd255);
    err_clr = 1'b1;
    drive(16'h0008, 32'h0000_0000);
    err_clr = 1'b0;
    check("t6_clr_wins", err_cnt[31:24], 8'd0);
`endif

    // No lanes enabled -> link down
    cfg_lane_en = '0;
    idle();
    idle();
    check("t4_none_link", link_lock, 1'b0);
    check("t4_none_lock", blk_lock, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
